// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter: shares the 16-bit external bus between microcode operand
// accesses (byte/word/long, split into one or two word cycles) and instruction
// prefetch, and raises finished / trap / prefetch completion pulses.
module bus_cycle_arbiter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        read_req,
    input  logic        write_req,
    input  logic [1:0]  size,
    input  logic [31:0] address,
    input  logic [31:0] data_write,
    output logic [31:0] data_read,
    output logic        finished,
    output logic [31:0] fault_address,
    input  logic        prefetch_req,
    input  logic [31:0] prefetch_address,
    output logic [15:0] prefetch_data,
    output logic        prefetch_done,
    output logic        prefetch_error,
    output logic        jmp_address_trap,
    output logic        jmp_bus_trap,
    output logic        bus_cyc,
    output logic        bus_we,
    output logic [30:0] bus_address,
    output logic [1:0]  bus_sel,
    output logic [15:0] bus_data_out,
    input  logic [15:0] bus_data_in,
    input  logic        bus_ack,
    input  logic        bus_err
);

    typedef enum logic [2:0] {IDLE, MC1, MC2, PF, DONE, TRAP} state_t;

    state_t      r_state, w_state;
    logic        r_is_long, w_is_long;
    logic        r_is_byte, w_is_byte;
    logic [15:0] r_low_word, w_low_word;
    logic [31:0] r_data_read, w_data_read;
    logic        r_finished, w_finished;
    logic [31:0] r_fault_address, w_fault_address;
    logic [15:0] r_prefetch_data, w_prefetch_data;
    logic        r_prefetch_done, w_prefetch_done;
    logic        r_prefetch_error, w_prefetch_error;
    logic        r_addr_trap, w_addr_trap;
    logic        r_bus_trap, w_bus_trap;
    logic        r_bus_cyc, w_bus_cyc;
    logic        r_bus_we, w_bus_we;
    logic [30:0] r_bus_address, w_bus_address;
    logic [1:0]  r_bus_sel, w_bus_sel;
    logic [15:0] r_bus_data_out, w_bus_data_out;

    // bus_err takes precedence over a simultaneous bus_ack
    logic w_ack;
    logic w_mc_req;
    logic w_misaligned;
    assign w_ack        = bus_ack & ~bus_err;
    assign w_mc_req     = read_req | write_req;
    assign w_misaligned = (size != 2'b00) && address[0];

    // Next-state and next-output computation; all outputs leave via registers
    always_comb begin
        w_state          = r_state;
        w_is_long        = r_is_long;
        w_is_byte        = r_is_byte;
        w_low_word       = r_low_word;
        w_data_read      = r_data_read;
        w_finished       = 1'b0;
        w_fault_address  = r_fault_address;
        w_prefetch_data  = r_prefetch_data;
        w_prefetch_done  = 1'b0;
        w_prefetch_error = 1'b0;
        w_addr_trap      = 1'b0;
        w_bus_trap       = 1'b0;
        w_bus_cyc        = r_bus_cyc;
        w_bus_we         = r_bus_we;
        w_bus_address    = r_bus_address;
        w_bus_sel        = r_bus_sel;
        w_bus_data_out   = r_bus_data_out;
        case (r_state)
            IDLE: begin
                if (w_mc_req) begin
                    if (w_misaligned) begin
                        w_state         = TRAP;
                        w_addr_trap     = 1'b1;
                        w_fault_address = address;
                    end else begin
                        w_state       = MC1;
                        w_is_long     = (size == 2'b10);
                        w_is_byte     = (size == 2'b00);
                        w_low_word    = data_write[15:0];
                        w_bus_cyc     = 1'b1;
                        // a simultaneous read and write request is serviced as a read
                        w_bus_we      = write_req & ~read_req;
                        w_bus_address = address[31:1];
                        if (size == 2'b00) begin
                            w_bus_sel      = address[0] ? 2'b01 : 2'b10;
                            w_bus_data_out = {data_write[7:0], data_write[7:0]};
                        end else if (size == 2'b10) begin
                            w_bus_sel      = 2'b11;
                            w_bus_data_out = data_write[31:16];
                        end else begin
                            w_bus_sel      = 2'b11;
                            w_bus_data_out = data_write[15:0];
                        end
                    end
                end else if (prefetch_req) begin
                    w_state       = PF;
                    w_bus_cyc     = 1'b1;
                    w_bus_we      = 1'b0;
                    w_bus_address = prefetch_address[31:1];
                    w_bus_sel     = 2'b11;
                end
            end
            MC1, MC2: begin
                if (bus_err) begin
                    w_state         = TRAP;
                    w_bus_trap      = 1'b1;
                    w_fault_address = {r_bus_address, 1'b0};
                    w_bus_cyc       = 1'b0;
                    w_bus_we        = 1'b0;
                    w_bus_sel       = 2'b00;
                end else if (w_ack) begin
                    if (r_state == MC1 && r_is_long) begin
                        // locked second half: stay on the bus for the low word
                        w_state        = MC2;
                        w_bus_address  = r_bus_address + 31'd1;
                        w_bus_data_out = r_low_word;
                        if (!r_bus_we)
                            w_data_read[31:16] = bus_data_in;
                    end else begin
                        w_state    = DONE;
                        w_finished = 1'b1;
                        w_bus_cyc  = 1'b0;
                        w_bus_we   = 1'b0;
                        w_bus_sel  = 2'b00;
                        if (!r_bus_we) begin
                            if (r_state == MC2)
                                w_data_read[15:0] = bus_data_in;
                            else if (r_is_byte)
                                w_data_read = {24'd0, r_bus_sel[1] ? bus_data_in[15:8]
                                                                   : bus_data_in[7:0]};
                            else
                                w_data_read = {16'd0, bus_data_in};
                        end
                    end
                end
            end
            PF: begin
                if (bus_ack || bus_err) begin
                    w_state          = IDLE;
                    w_prefetch_data  = bus_data_in;
                    w_prefetch_done  = 1'b1;
                    w_prefetch_error = bus_err;
                    w_bus_cyc        = 1'b0;
                    w_bus_sel        = 2'b00;
                end
            end
            // one cycle of pulse, requests ignored so a held request is not reissued
            DONE, TRAP: w_state = IDLE;
            default:    w_state = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously so a cycle in flight is abandoned
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_is_long        <= 1'b0;
            r_is_byte        <= 1'b0;
            r_low_word       <= 16'd0;
            r_data_read      <= 32'd0;
            r_finished       <= 1'b0;
            r_fault_address  <= 32'd0;
            r_prefetch_data  <= 16'd0;
            r_prefetch_done  <= 1'b0;
            r_prefetch_error <= 1'b0;
            r_addr_trap      <= 1'b0;
            r_bus_trap       <= 1'b0;
            r_bus_cyc        <= 1'b0;
            r_bus_we         <= 1'b0;
            r_bus_address    <= 31'd0;
            r_bus_sel        <= 2'b00;
            r_bus_data_out   <= 16'd0;
        end else begin
            r_state          <= w_state;
            r_is_long        <= w_is_long;
            r_is_byte        <= w_is_byte;
            r_low_word       <= w_low_word;
            r_data_read      <= w_data_read;
            r_finished       <= w_finished;
            r_fault_address  <= w_fault_address;
            r_prefetch_data  <= w_prefetch_data;
            r_prefetch_done  <= w_prefetch_done;
            r_prefetch_error <= w_prefetch_error;
            r_addr_trap      <= w_addr_trap;
            r_bus_trap       <= w_bus_trap;
            r_bus_cyc        <= w_bus_cyc;
            r_bus_we         <= w_bus_we;
            r_bus_address    <= w_bus_address;
            r_bus_sel        <= w_bus_sel;
            r_bus_data_out   <= w_bus_data_out;
        end
    end

    assign data_read        = r_data_read;
    assign finished         = r_finished;
    assign fault_address    = r_fault_address;
    assign prefetch_data    = r_prefetch_data;
    assign prefetch_done    = r_prefetch_done;
    assign prefetch_error   = r_prefetch_error;
    assign jmp_address_trap = r_addr_trap;
    assign jmp_bus_trap     = r_bus_trap;
    assign bus_cyc          = r_bus_cyc;
    assign bus_we           = r_bus_we;
    assign bus_address      = r_bus_address;
    assign bus_sel          = r_bus_sel;
    assign bus_data_out     = r_bus_data_out;

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Directed testbench for bus_cycle_arbiter: inputs change and outputs are
// sampled 1 ns after each rising clock edge.
module tb_bus_cycle_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        read_req, write_req;
    logic [1:0]  size;
    logic [31:0] address, data_write, data_read;
    logic        finished;
    logic [31:0] fault_address;
    logic        prefetch_req;
    logic [31:0] prefetch_address;
    logic [15:0] prefetch_data;
    logic        prefetch_done, prefetch_error;
    logic        jmp_address_trap, jmp_bus_trap;
    logic        bus_cyc, bus_we;
    logic [30:0] bus_address;
    logic [1:0]  bus_sel;
    logic [15:0] bus_data_out, bus_data_in;
    logic        bus_ack, bus_err;

    int checks   = 0;
    int failures = 0;

    bus_cycle_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .read_req(read_req), .write_req(write_req), .size(size),
        .address(address), .data_write(data_write), .data_read(data_read),
        .finished(finished), .fault_address(fault_address),
        .prefetch_req(prefetch_req), .prefetch_address(prefetch_address),
        .prefetch_data(prefetch_data), .prefetch_done(prefetch_done),
        .prefetch_error(prefetch_error),
        .jmp_address_trap(jmp_address_trap), .jmp_bus_trap(jmp_bus_trap),
        .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_address(bus_address),
        .bus_sel(bus_sel), .bus_data_out(bus_data_out),
        .bus_data_in(bus_data_in), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; read_req = 0; write_req = 0; size = 2'b00;
        address = 0; data_write = 0; prefetch_req = 0; prefetch_address = 0;
        bus_data_in = 0; bus_ack = 0; bus_err = 0;
        tick(); tick();
        chk("rst_bus_cyc", {31'd0, bus_cyc}, 32'd0);
        chk("rst_finished", {31'd0, finished}, 32'd0);
        chk("rst_data_read", data_read, 32'd0);
        chk("rst_bus_address", {1'b0, bus_address}, 32'd0);
        chk("rst_fault", fault_address, 32'd0);
        reset_n = 1'b1;
        tick();

        // word read 0x1000, zero wait, 0xBEEF
        read_req = 1; size = 2'b01; address = 32'h1000; bus_ack = 1; bus_data_in = 16'hBEEF;
        tick();
        $display("word read: cyc=%0b sel=%b addr=%h", bus_cyc, bus_sel, bus_address);
        chk("wr_c1_cyc", {31'd0, bus_cyc}, 32'd1);
        chk("wr_c1_sel", {30'd0, bus_sel}, 32'd3);
        chk("wr_c1_addr", {1'b0, bus_address}, 32'h800);
        chk("wr_c1_we", {31'd0, bus_we}, 32'd0);
        chk("wr_c1_fin", {31'd0, finished}, 32'd0);
        tick();
        chk("wr_c2_fin", {31'd0, finished}, 32'd1);
        chk("wr_c2_data", data_read, 32'h0000BEEF);
        chk("wr_c2_cyc", {31'd0, bus_cyc}, 32'd0);
        read_req = 0; bus_ack = 0;
        tick();
        chk("wr_c3_fin", {31'd0, finished}, 32'd0);

        // long write 0x2000 = 0x12345678, one wait state per word, prefetch raised in cycle 1
        write_req = 1; size = 2'b10; address = 32'h2000; data_write = 32'h12345678;
        tick();
        $display("long write: cyc=%0b we=%0b addr=%h dout=%h", bus_cyc, bus_we, bus_address, bus_data_out);
        chk("lw_c1_addr", {1'b0, bus_address}, 32'h1000);
        chk("lw_c1_dout", {16'd0, bus_data_out}, 32'h1234);
        chk("lw_c1_we", {31'd0, bus_we}, 32'd1);
        prefetch_req = 1; prefetch_address = 32'h6001;
        tick();
        chk("lw_c2_cyc", {31'd0, bus_cyc}, 32'd1);
        chk("lw_c2_addr", {1'b0, bus_address}, 32'h1000);
        bus_ack = 1;
        tick();
        chk("lw_c3_addr", {1'b0, bus_address}, 32'h1001);
        chk("lw_c3_dout", {16'd0, bus_data_out}, 32'h5678);
        chk("lw_c3_we", {31'd0, bus_we}, 32'd1);
        bus_ack = 0;
        tick();
        chk("lw_c4_fin", {31'd0, finished}, 32'd0);
        bus_ack = 1;
        tick();
        chk("lw_c5_fin", {31'd0, finished}, 32'd1);
        chk("lw_c5_cyc", {31'd0, bus_cyc}, 32'd0);
        write_req = 0; bus_ack = 0;
        tick();
        chk("lw_c6_no_pf", {31'd0, bus_cyc}, 32'd0);
        chk("lw_c6_fin", {31'd0, finished}, 32'd0);
        tick();
        $display("prefetch: cyc=%0b addr=%h sel=%b", bus_cyc, bus_address, bus_sel);
        chk("pf_c7_cyc", {31'd0, bus_cyc}, 32'd1);
        chk("pf_c7_addr", {1'b0, bus_address}, 32'h3000);
        chk("pf_c7_we", {31'd0, bus_we}, 32'd0);
        chk("pf_c7_sel", {30'd0, bus_sel}, 32'd3);
        bus_ack = 1; bus_data_in = 16'hCAFE;
        tick();
        chk("pf_c8_done", {31'd0, prefetch_done}, 32'd1);
        chk("pf_c8_data", {16'd0, prefetch_data}, 32'h0000CAFE);
        chk("pf_c8_err", {31'd0, prefetch_error}, 32'd0);
        prefetch_req = 0; bus_ack = 0;
        tick();
        chk("pf_c9_done", {31'd0, prefetch_done}, 32'd0);

        // byte read 0x3001 -> odd lane
        read_req = 1; size = 2'b00; address = 32'h3001; bus_ack = 1; bus_data_in = 16'h00AB;
        tick();
        $display("byte read: sel=%b addr=%h", bus_sel, bus_address);
        chk("br_c1_sel", {30'd0, bus_sel}, 32'd1);
        chk("br_c1_addr", {1'b0, bus_address}, 32'h1800);
        tick();
        chk("br_c2_fin", {31'd0, finished}, 32'd1);
        chk("br_c2_data", data_read, 32'h000000AB);
        read_req = 0; bus_ack = 0;
        tick();

        // byte write 0x3000 -> even lane, byte replicated
        write_req = 1; size = 2'b00; address = 32'h3000; data_write = 32'hFFFFFF5A; bus_ack = 1;
        tick();
        $display("byte write: sel=%b dout=%h", bus_sel, bus_data_out);
        chk("bw_c1_sel", {30'd0, bus_sel}, 32'd2);
        chk("bw_c1_dout", {16'd0, bus_data_out}, 32'h5A5A);
        tick();
        chk("bw_c2_fin", {31'd0, finished}, 32'd1);
        chk("bw_c2_data_kept", data_read, 32'h000000AB);
        write_req = 0; bus_ack = 0;
        tick();

        // odd word address -> address trap, no bus cycle
        read_req = 1; size = 2'b01; address = 32'h4001;
        tick();
        $display("addr trap: trap=%0b fault=%h cyc=%0b", jmp_address_trap, fault_address, bus_cyc);
        chk("at_c1_trap", {31'd0, jmp_address_trap}, 32'd1);
        chk("at_c1_cyc", {31'd0, bus_cyc}, 32'd0);
        chk("at_c1_fault", fault_address, 32'h4001);
        chk("at_c1_fin", {31'd0, finished}, 32'd0);
        read_req = 0;
        tick();
        chk("at_c2_trap", {31'd0, jmp_address_trap}, 32'd0);
        chk("at_c2_fin", {31'd0, finished}, 32'd0);

        // long read 0x5000, error on second word
        read_req = 1; size = 2'b10; address = 32'h5000; bus_ack = 1; bus_data_in = 16'h1111;
        tick();
        chk("le_c1_addr", {1'b0, bus_address}, 32'h2800);
        tick();
        chk("le_c2_addr", {1'b0, bus_address}, 32'h2801);
        bus_ack = 0; bus_err = 1;
        tick();
        $display("bus trap: trap=%0b fault=%h fin=%0b", jmp_bus_trap, fault_address, finished);
        chk("le_c3_trap", {31'd0, jmp_bus_trap}, 32'd1);
        chk("le_c3_fault", fault_address, 32'h5002);
        chk("le_c3_fin", {31'd0, finished}, 32'd0);
        chk("le_c3_cyc", {31'd0, bus_cyc}, 32'd0);
        read_req = 0; bus_err = 0;
        tick();
        chk("le_c4_trap", {31'd0, jmp_bus_trap}, 32'd0);
        chk("le_c4_fin", {31'd0, finished}, 32'd0);

        // simultaneous read+write+prefetch: read first, then prefetch with error
        read_req = 1; write_req = 1; size = 2'b01; address = 32'h7000;
        prefetch_req = 1; prefetch_address = 32'h8000; bus_ack = 1; bus_data_in = 16'h4242;
        tick();
        chk("pr_c1_addr", {1'b0, bus_address}, 32'h3800);
        chk("pr_c1_we", {31'd0, bus_we}, 32'd0);
        tick();
        chk("pr_c2_fin", {31'd0, finished}, 32'd1);
        chk("pr_c2_data", data_read, 32'h00004242);
        read_req = 0; write_req = 0;
        tick();
        chk("pr_c3_cyc", {31'd0, bus_cyc}, 32'd0);
        bus_err = 1;
        tick();
        chk("pr_c4_addr", {1'b0, bus_address}, 32'h4000);
        chk("pr_c4_cyc", {31'd0, bus_cyc}, 32'd1);
        tick();
        $display("prefetch err: done=%0b err=%0b bustrap=%0b", prefetch_done, prefetch_error, jmp_bus_trap);
        chk("pr_c5_done", {31'd0, prefetch_done}, 32'd1);
        chk("pr_c5_err", {31'd0, prefetch_error}, 32'd1);
        chk("pr_c5_notrap", {31'd0, jmp_bus_trap}, 32'd0);
        prefetch_req = 0; bus_err = 0; bus_ack = 0;
        tick();

        // reset pulsed mid-cycle
        read_req = 1; size = 2'b01; address = 32'h1000;
        tick();
        chk("rs_c1_cyc", {31'd0, bus_cyc}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        $display("mid reset: cyc=%0b addr=%h data=%h", bus_cyc, bus_address, data_read);
        chk("rs_cyc", {31'd0, bus_cyc}, 32'd0);
        chk("rs_addr", {1'b0, bus_address}, 32'd0);
        chk("rs_data", data_read, 32'd0);
        read_req = 0;
        tick();
        reset_n = 1'b1;
        tick();
        read_req = 1; size = 2'b01; address = 32'h0A00; bus_ack = 1; bus_data_in = 16'h0055;
        tick();
        chk("rs_post_cyc", {31'd0, bus_cyc}, 32'd1);
        chk("rs_post_addr", {1'b0, bus_address}, 32'h500);
        tick();
        chk("rs_post_fin", {31'd0, finished}, 32'd1);
        read_req = 0; bus_ack = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
